// File: rtl/cu_multicycle_gen_if.sv
// Control-unit bus: instruction and handshake inputs into the CU, and the
// decoded control strobes and fields from the CU out to the datapath.
interface cu_multicycle_gen_if #(
  parameter int INST_W = 16,
  parameter int OP_W   = 4,
  parameter int REG_W  = 4,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic [INST_W-1:0] inst;
  logic              mem_rdy;
  logic              alu_done;
  logic              resume;
  logic              pc_ld;
  logic              ir_ld;
  logic              mem_en;
  logic              mem_wrt;
  logic              stat_ld;
  logic              alu_en;
  logic              alu_flag;
  logic              pc_branch;
  logic              flush;
  logic              halted;
  logic [OP_W-1:0]   opcode;
  logic [REG_W-1:0]  reg_out;
  logic [ADDR_W-1:0] branch_addr;
  logic [CNT_W-1:0]  retired;

  // Control-unit side.
  modport master (
    input  inst, mem_rdy, alu_done, resume,
    output pc_ld, ir_ld, mem_en, mem_wrt, stat_ld, alu_en, alu_flag,
           pc_branch, flush, halted, opcode, reg_out, branch_addr, retired
  );

  // Datapath side.
  modport slave (
    output inst, mem_rdy, alu_done, resume,
    input  pc_ld, ir_ld, mem_en, mem_wrt, stat_ld, alu_en, alu_flag,
           pc_branch, flush, halted, opcode, reg_out, branch_addr, retired
  );
endinterface

// File: rtl/cu_multicycle_gen.sv
// Multicycle control unit: FETCH -> DECODE -> EXECUTE -> WRITEBACK with
// memory/ALU ready handshakes, a HALT state and a retired-instruction counter.
// Only the state and the counter are registered; every output is decoded
// combinationally from state, the IR word and the handshake inputs.
module cu_multicycle_gen #(
  parameter int INST_W  = 16,
  parameter int OP_W    = 4,
  parameter int REG_W   = 4,
  parameter int ADDR_W  = 8,
  parameter int ALU_MAX = 10,
  parameter int OP_SUB  = 1,
  parameter int OP_JMP  = 11,
  parameter int OP_LDI  = 12,
  parameter int OP_HLT  = 15,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  cu_multicycle_gen_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic [OP_W-1:0]   op_field;
  logic [REG_W-1:0]  reg_field;
  logic [ADDR_W-1:0] addr_field;
  logic              is_alu;

  assign op_field   = bus.inst[INST_W-1 -: OP_W];
  assign reg_field  = bus.inst[INST_W-OP_W-1 -: REG_W];
  assign addr_field = bus.inst[ADDR_W-1:0];
  assign is_alu     = (op_field <= OP_W'(ALU_MAX));

  // State register and retired counter; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Next-state and control decode; reset forces all outputs quiet.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d         = state_q;
    retire          = 1'b0;
    bus.pc_ld       = 1'b0;
    bus.ir_ld       = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_wrt     = 1'b0;
    bus.stat_ld     = 1'b0;
    bus.alu_en      = 1'b0;
    bus.alu_flag    = 1'b0;
    bus.pc_branch   = 1'b0;
    bus.flush       = 1'b0;
    bus.halted      = 1'b0;
    bus.opcode      = '1;
    bus.reg_out     = '0;
    bus.branch_addr = '0;
    bus.retired     = retired_q;

    case (state_q)
      S_FETCH: begin
        bus.mem_en = 1'b1;
        if (bus.mem_rdy) begin
          bus.pc_ld = 1'b1;
          bus.ir_ld = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.mem_en  = 1'b1;
        bus.opcode  = op_field;
        bus.reg_out = reg_field;
        state_d     = S_EXECUTE;
      end
      S_EXECUTE: begin
        bus.mem_en      = 1'b1;
        bus.opcode      = op_field;
        bus.reg_out     = reg_field;
        bus.branch_addr = addr_field;
        if (is_alu) begin
          bus.alu_en   = 1'b1;
          bus.alu_flag = (op_field == OP_W'(OP_SUB));
          if (bus.alu_done) state_d = S_WRITEBACK;
        end else if (op_field == OP_W'(OP_JMP)) begin
          bus.pc_branch = 1'b1;
          bus.flush     = 1'b1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end else if (op_field == OP_W'(OP_LDI)) begin
          state_d = S_WRITEBACK;
        end else if (op_field == OP_W'(OP_HLT)) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        bus.mem_en  = 1'b1;
        bus.mem_wrt = 1'b1;
        bus.opcode  = op_field;
        bus.reg_out = reg_field;
        if (bus.mem_rdy) begin
          bus.stat_ld = is_alu;
          retire      = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_HALT: begin
        bus.halted = 1'b1;
        if (bus.resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      retire          = 1'b0;
      bus.pc_ld       = 1'b0;
      bus.ir_ld       = 1'b0;
      bus.mem_en      = 1'b0;
      bus.mem_wrt     = 1'b0;
      bus.stat_ld     = 1'b0;
      bus.alu_en      = 1'b0;
      bus.alu_flag    = 1'b0;
      bus.pc_branch   = 1'b0;
      bus.flush       = 1'b0;
      bus.halted      = 1'b0;
      bus.opcode      = '1;
      bus.reg_out     = '0;
      bus.branch_addr = '0;
      bus.retired     = '0;
    end
  end

endmodule
